// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_pkg
// Brief   : Shared constants and helpers for the instruction-fetch stage.
// Revision: 1.0
// ============================================================================
package if_stage_pkg;

    localparam logic [31:0] c_core_nop_instr   = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : fetch_queue
// Brief   : In-order fetch FIFO; entries are allocated on request accept and
//           filled with returned data oldest-first, then popped from the head.
// Revision: 1.0
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       alloc,
    input  logic [31:0]                alloc_pc,
    input  logic                       fill,
    input  logic [31:0]                fill_data,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] unfilled,
    output logic                       head_filled,
    output logic [31:0]                head_pc,
    output logic [31:0]                head_instr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_fl_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_nfilled;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Filled entries always form a prefix from the head, so the fill pointer
    // simply trails the write pointer.
    always_ff @(posedge clk) begin
        if (alloc) begin
            r_pc[r_wr_ptr] <= alloc_pc;
        end
        if (fill) begin
            r_instr[r_fl_ptr] <= fill_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_fl_ptr  <= '0;
            r_count   <= '0;
            r_nfilled <= '0;
        end else if (clear) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_fl_ptr  <= '0;
            r_count   <= '0;
            r_nfilled <= '0;
        end else begin
            if (alloc) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (fill) begin
                r_fl_ptr <= ptr_inc(r_fl_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count   <= r_count   + CW'(alloc) - CW'(pop);
            r_nfilled <= r_nfilled + CW'(fill)  - CW'(pop);
        end
    end

    assign count       = r_count;
    assign unfilled    = r_count - r_nfilled;
    assign head_filled = (r_nfilled != '0);
    assign head_pc     = r_pc[r_rd_ptr];
    assign head_instr  = r_instr[r_rd_ptr];

endmodule : fetch_queue
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module  : if_stage
// Brief   : Instruction-fetch stage: PC generation, pipelined ibus requests,
//           redirect handling with in-flight response dropping, IF/ID register.
// Revision: 1.0
// ============================================================================
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_stall,
    input  logic        branch_take,
    input  logic [31:0] branch_pc,
    input  logic        trap_take,
    input  logic [31:0] trap_pc,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ready,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic        if2id_valid,
    output logic [31:0] if2id_pc,
    output logic [31:0] if2id_instruction
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   r_pc_q;
    logic [CW-1:0] r_drop_cnt;
    logic          r_run;
    logic          r_if2id_valid;
    logic [31:0]   r_if2id_pc;
    logic [31:0]   r_if2id_instr;

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_room;
    logic          w_req;
    logic          w_accept;
    logic          w_rsp_drop;
    logic          w_fill;
    logic          w_pop;
    logic          w_rsp_inflight;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_unfilled;
    logic          w_head_filled;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;

    assign w_redirect = trap_take | branch_take;
    assign w_target   = word_align(trap_take ? trap_pc : branch_pc);

    // Outstanding plus to-be-dropped responses never exceed DEPTH, so CW bits hold the sum.
    assign w_room   = (w_count + r_drop_cnt) < CW'(DEPTH);
    assign w_req    = r_run & w_room & ~w_redirect;
    assign w_accept = w_req & ibus_ready;

    assign w_rsp_inflight = (w_unfilled != '0) || (r_drop_cnt != '0);
    assign w_rsp_drop     = ibus_rvalid & (r_drop_cnt != '0);
    assign w_fill         = ibus_rvalid & (r_drop_cnt == '0) & (w_unfilled != '0) & ~w_redirect;
    assign w_pop          = ~w_redirect & ~if_stall & w_head_filled;

    fetch_queue #(
        .DEPTH(DEPTH)
    ) u_fetch_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_redirect),
        .alloc      (w_accept),
        .alloc_pc   (r_pc_q),
        .fill       (w_fill),
        .fill_data  (ibus_rdata),
        .pop        (w_pop),
        .count      (w_count),
        .unfilled   (w_unfilled),
        .head_filled(w_head_filled),
        .head_pc    (w_head_pc),
        .head_instr (w_head_instr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_pc_q     <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_redirect) begin
                r_pc_q <= w_target;
                // Every response still owed by the bus is discarded, minus one
                // arriving right now.
                r_drop_cnt <= w_unfilled + r_drop_cnt - CW'(ibus_rvalid & w_rsp_inflight);
            end else begin
                if (w_accept) begin
                    r_pc_q <= r_pc_q + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if2id_valid <= 1'b0;
            r_if2id_pc    <= RESET_PC;
            r_if2id_instr <= c_core_nop_instr;
        end else if (w_redirect) begin
            r_if2id_valid <= 1'b0;
        end else if (!if_stall) begin
            r_if2id_valid <= w_head_filled;
            if (w_head_filled) begin
                r_if2id_pc    <= w_head_pc;
                r_if2id_instr <= w_head_instr;
            end
        end
    end

    assign ibus_req          = w_req;
    assign ibus_addr         = r_pc_q;
    assign if2id_valid       = r_if2id_valid;
    assign if2id_pc          = r_if2id_pc;
    assign if2id_instruction = r_if2id_instr;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage
// Brief   : Scoreboard bench for if_stage with an in-order ibus responder model.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        if_stall;
    logic        branch_take;
    logic [31:0] branch_pc;
    logic        trap_take;
    logic [31:0] trap_pc;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ready;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        if2id_valid;
    logic [31:0] if2id_pc;
    logic [31:0] if2id_instruction;

    if_stage #(
        .RESET_PC(RST_PC),
        .DEPTH   (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_stall         (if_stall),
        .branch_take      (branch_take),
        .branch_pc        (branch_pc),
        .trap_take        (trap_take),
        .trap_pc          (trap_pc),
        .ibus_req         (ibus_req),
        .ibus_addr        (ibus_addr),
        .ibus_ready       (ibus_ready),
        .ibus_rvalid      (ibus_rvalid),
        .ibus_rdata       (ibus_rdata),
        .if2id_valid      (if2id_valid),
        .if2id_pc         (if2id_pc),
        .if2id_instruction(if2id_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
    typedef struct { logic [31:0] data; int due; } rsp_t;

    exp_t        exp_q[$];
    rsp_t        bus_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          first_acc_cyc = -1;
    int          first_val_cyc = -1;
    logic        chk_next      = 1'b1;
    logic [31:0] next_addr     = RST_PC;
    logic        prev_stall    = 1'b0;
    logic        prev_redirect = 1'b0;
    logic        snap_valid    = 1'b0;
    logic [31:0] snap_pc       = '0;
    logic [31:0] snap_instr    = '0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Bus and pipeline observer: records accepts and consumed responses at the edge.
    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            if (trap_take || branch_take) begin
                check_eq("req_in_redirect", 32'(ibus_req), 32'd0);
                exp_q.delete();
                chk_next  = 1'b1;
                next_addr = trap_take ? {trap_pc[31:2], 2'b00} : {branch_pc[31:2], 2'b00};
            end
            if (ibus_rvalid) begin
                assert (bus_q.size() > 0) else $error("rvalid without outstanding request");
                if (bus_q.size() > 0) void'(bus_q.pop_front());
            end
            if (ibus_req && ibus_ready) begin
                if (chk_next) begin
                    check_eq("fetch_start_addr", ibus_addr, next_addr);
                    chk_next = 1'b0;
                end
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                bus_q.push_back('{mem(ibus_addr), cyc + lat - 1});
                exp_q.push_back('{ibus_addr, mem(ibus_addr)});
            end
            prev_stall    = if_stall;
            prev_redirect = trap_take | branch_take;
            snap_valid    = if2id_valid;
            snap_pc       = if2id_pc;
            snap_instr    = if2id_instruction;
        end
    end

    // IF/ID checker and bus responder, both away from the active edge.
    always @(negedge clk) begin
        if (rst_n && cyc > 0) begin
            if (prev_redirect) begin
                check_eq("valid_after_redirect", 32'(if2id_valid), 32'd0);
            end else if (prev_stall) begin
                check_eq("stall_hold_valid", 32'(if2id_valid), 32'(snap_valid));
                check_eq("stall_hold_pc", if2id_pc, snap_pc);
                check_eq("stall_hold_instr", if2id_instruction, snap_instr);
            end else if (if2id_valid) begin
                exp_t e;
                e = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
                if (exp_q.size() > 0) e = exp_q.pop_front();
                if (first_val_cyc < 0) first_val_cyc = cyc;
                check_eq("if2id_pc", if2id_pc, e.pc);
                check_eq("if2id_instr", if2id_instruction, e.instr);
            end
        end
        ibus_rvalid = rst_n && (bus_q.size() > 0) && (bus_q[0].due <= cyc);
        ibus_rdata  = ibus_rvalid ? bus_q[0].data : 32'h0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        rst_n       = 1'b0;
        if_stall    = 1'b0;
        branch_take = 1'b0;
        branch_pc   = '0;
        trap_take   = 1'b0;
        trap_pc     = '0;
        ibus_ready  = 1'b1;
        ibus_rvalid = 1'b0;
        ibus_rdata  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_req", 32'(ibus_req), 32'd0);
        check_eq("rst_valid", 32'(if2id_valid), 32'd0);
        check_eq("rst_pc", if2id_pc, RST_PC);
        check_eq("rst_instr", if2id_instruction, NOP);
        rst_n = 1'b1;

        // Sequential fetch from reset.
        repeat (12) @(negedge clk);
        check_eq("first_valid_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);

        // Stall three cycles: queue fills and requests stop.
        if_stall = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("req_gated_when_full", 32'(ibus_req), 32'd0);
        @(negedge clk);
        if_stall = 1'b0;
        repeat (10) @(negedge clk);

        // Branch with slow bus so responses are in flight.
        lat = 3;
        repeat (8) @(negedge clk);
        branch_take = 1'b1;
        branch_pc   = 32'h0000_0100;
        @(negedge clk);
        branch_take = 1'b0;
        repeat (16) @(negedge clk);
        lat = 1;
        repeat (4) @(negedge clk);

        // Trap and branch together with a coincident response.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus_q.size() > 0 && bus_q[0].due <= cyc) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("coincident_rsp_found", 32'(found), 32'd1);
        trap_take   = 1'b1;
        trap_pc     = 32'h0000_0082;
        branch_take = 1'b1;
        branch_pc   = 32'h0000_0200;
        @(negedge clk);
        trap_take   = 1'b0;
        branch_take = 1'b0;
        repeat (12) @(negedge clk);

        // Bus back-pressure: request and address must hold.
        ibus_ready = 1'b0;
        repeat (2) @(negedge clk);
        begin
            logic [31:0] held;
            held = ibus_addr;
            for (int i = 0; i < 4; i++) begin
                check_eq("bp_req_high", 32'(ibus_req), 32'd1);
                check_eq("bp_addr_stable", ibus_addr, held);
                @(negedge clk);
            end
        end
        ibus_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-stream.
        #2 rst_n = 1'b0;
        bus_q.delete();
        exp_q.delete();
        prev_stall    = 1'b0;
        prev_redirect = 1'b0;
        chk_next      = 1'b1;
        next_addr     = RST_PC;
        first_acc_cyc = -1;
        first_val_cyc = -1;
        #1;
        check_eq("async_rst_req", 32'(ibus_req), 32'd0);
        check_eq("async_rst_valid", 32'(if2id_valid), 32'd0);
        check_eq("async_rst_pc", if2id_pc, RST_PC);
        check_eq("async_rst_instr", if2id_instruction, NOP);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("restart_latency", 32'(first_val_cyc - first_acc_cyc), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire
